// File: rtl/stage_x_if.sv
// rtl/stage_x_if.sv - decode-to-execute bus and execute-stage result bus
interface stage_x_if;
    logic        d_valid;
    logic        d_illegal_instr;
    logic [31:0] d_pc;
    logic [31:0] d_npc;
    logic [5:0]  d_opcode;
    logic [5:0]  d_fn;
    logic [5:0]  d_rt;
    logic [4:0]  d_sa;
    logic [31:0] d_target;
    logic [5:0]  d_wbr;
    logic [31:0] d_op1_val;
    logic [31:0] d_op2_val;
    logic [31:0] d_rt_val;
    logic [31:0] d_simm;
    logic        d_flush_X;

    logic        x_valid;
    logic [31:0] x_pc;
    logic [5:0]  x_wbr;
    logic [31:0] x_res;
    logic [5:0]  x_opcode;
    logic [31:0] x_address;
    logic [31:0] x_store_data;
    logic        x_restart;
    logic [31:0] x_restart_pc;
    logic        x_flush_D;
    logic        x_md_busy;

    modport master (
        output d_valid, d_illegal_instr, d_pc, d_npc, d_opcode, d_fn, d_rt, d_sa,
               d_target, d_wbr, d_op1_val, d_op2_val, d_rt_val, d_simm, d_flush_X,
        input  x_valid, x_pc, x_wbr, x_res, x_opcode, x_address, x_store_data,
               x_restart, x_restart_pc, x_flush_D, x_md_busy
    );

    modport slave (
        input  d_valid, d_illegal_instr, d_pc, d_npc, d_opcode, d_fn, d_rt, d_sa,
               d_target, d_wbr, d_op1_val, d_op2_val, d_rt_val, d_simm, d_flush_X,
        output x_valid, x_pc, x_wbr, x_res, x_opcode, x_address, x_store_data,
               x_restart, x_restart_pc, x_flush_D, x_md_busy
    );
endinterface

// File: rtl/stage_x.sv
// rtl/stage_x.sv - execute stage: ALU, branch resolution, iterative HI/LO multiply/divide
module stage_x #(
    parameter int MD_CYCLES = 32,
    parameter bit debug     = 1'b0
) (
    input  logic     clock,
    input  logic     rst_n,
    stage_x_if.slave xif
);
    localparam int CW = $clog2(MD_CYCLES + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                           OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                           OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_JR   = 6'h08, FN_JALR = 6'h09, FN_MFHI = 6'h10,
                           FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
                           FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A,
                           FN_DIVU = 6'h1B, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                           FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                           FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                           FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    logic [31:0] op1, op2, rtv, simm;
    assign op1  = xif.d_op1_val;
    assign op2  = xif.d_op2_val;
    assign rtv  = xif.d_rt_val;
    assign simm = xif.d_simm;

    // Registered outputs
    logic        x_valid_r, x_restart_r, x_flush_d_r, kill_next;
    logic [5:0]  x_wbr_r, x_opcode_r;
    logic [31:0] x_pc_r, x_res_r, x_address_r, x_store_data_r, x_restart_pc_r;

    // HI/LO unit state
    logic [31:0] hi, lo, md_a;
    logic [63:0] md_p, md_step;
    logic [CW-1:0] md_cnt;
    logic        md_is_div, md_neg_lo, md_neg_hi, md_div_zero;
    logic        md_busy;
    assign md_busy = (md_cnt != '0);

    // Decode results
    logic [31:0] alu_res, br_target;
    logic        taken, link, use_op1_target;
    logic        md_start, md_signed, md_div, mf_hi, mf_lo, mt_hi, mt_lo, md_access;
    logic        live, legal, conflict, br_restart;
    logic        do_start, do_mthi, do_mtlo;

    // Decode the instruction in D: ALU result, branch outcome and HI/LO unit requests
    always_comb begin
        alu_res        = op1 + op2;
        taken          = 1'b0;
        link           = 1'b0;
        use_op1_target = 1'b0;
        md_start       = 1'b0;
        md_signed      = 1'b0;
        md_div         = 1'b0;
        mf_hi          = 1'b0;
        mf_lo          = 1'b0;
        mt_hi          = 1'b0;
        mt_lo          = 1'b0;
        case (xif.d_opcode)
            OP_SPECIAL: begin
                case (xif.d_fn)
                    FN_SLL:  alu_res = rtv << xif.d_sa;
                    FN_SRL:  alu_res = rtv >> xif.d_sa;
                    FN_SRA:  alu_res = $unsigned($signed(rtv) >>> xif.d_sa);
                    FN_SLLV: alu_res = rtv << op1[4:0];
                    FN_SRLV: alu_res = rtv >> op1[4:0];
                    FN_SRAV: alu_res = $unsigned($signed(rtv) >>> op1[4:0]);
                    FN_JR:   begin taken = 1'b1; use_op1_target = 1'b1; end
                    FN_JALR: begin taken = 1'b1; use_op1_target = 1'b1; link = 1'b1; end
                    FN_MFHI: mf_hi = 1'b1;
                    FN_MFLO: mf_lo = 1'b1;
                    FN_MTHI: mt_hi = 1'b1;
                    FN_MTLO: mt_lo = 1'b1;
                    FN_MULT: begin md_start = 1'b1; md_signed = 1'b1; end
                    FN_MULTU: md_start = 1'b1;
                    FN_DIV:  begin md_start = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
                    FN_DIVU: begin md_start = 1'b1; md_div = 1'b1; end
                    FN_ADD, FN_ADDU: alu_res = op1 + op2;
                    FN_SUB, FN_SUBU: alu_res = op1 - op2;
                    FN_AND:  alu_res = op1 & op2;
                    FN_OR:   alu_res = op1 | op2;
                    FN_XOR:  alu_res = op1 ^ op2;
                    FN_NOR:  alu_res = ~(op1 | op2);
                    FN_SLT:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
                    FN_SLTU: alu_res = {31'd0, op1 < op2};
                    default: alu_res = op1 + op2;
                endcase
            end
            OP_REGIMM: begin
                // rt[0] selects BGEZ over BLTZ, rt[4] selects the linking form
                taken = xif.d_rt[0] ? ~op1[31] : op1[31];
                link  = xif.d_rt[4];
            end
            OP_J:     taken = 1'b1;
            OP_JAL:   begin taken = 1'b1; link = 1'b1; end
            OP_BEQ:   taken = (op1 == rtv);
            OP_BNE:   taken = (op1 != rtv);
            OP_BLEZ:  taken = op1[31] | (op1 == 32'd0);
            OP_BGTZ:  taken = ~op1[31] & (op1 != 32'd0);
            OP_ADDI, OP_ADDIU: alu_res = op1 + op2;
            OP_SLTI:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
            OP_SLTIU: alu_res = {31'd0, op1 < op2};
            OP_ANDI:  alu_res = op1 & {16'd0, simm[15:0]};
            OP_ORI:   alu_res = op1 | {16'd0, simm[15:0]};
            OP_XORI:  alu_res = op1 ^ {16'd0, simm[15:0]};
            OP_LUI:   alu_res = {simm[15:0], 16'd0};
            default:  alu_res = op1 + op2;
        endcase
        if (link) begin
            alu_res = xif.d_npc + 32'd4;
        end else if (mf_hi) begin
            alu_res = hi;
        end else if (mf_lo) begin
            alu_res = lo;
        end
    end

    assign md_access  = md_start | mf_hi | mf_lo | mt_hi | mt_lo;
    assign br_target  = use_op1_target ? op1 : xif.d_target;
    assign live       = xif.d_valid & ~xif.d_flush_X & ~kill_next;
    assign legal      = ~xif.d_illegal_instr;
    assign conflict   = live & legal & md_access & md_busy;
    assign br_restart = live & legal & taken;
    assign do_start   = live & legal & md_start & ~md_busy;
    assign do_mthi    = live & legal & mt_hi & ~md_busy;
    assign do_mtlo    = live & legal & mt_lo & ~md_busy;

    // Register the X-stage result; a busy conflict restarts the instruction and kills its successor
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            x_valid_r      <= 1'b0;
            x_pc_r         <= '0;
            x_wbr_r        <= '0;
            x_res_r        <= '0;
            x_opcode_r     <= '0;
            x_address_r    <= '0;
            x_store_data_r <= '0;
            x_restart_r    <= 1'b0;
            x_restart_pc_r <= '0;
            x_flush_d_r    <= 1'b0;
            kill_next      <= 1'b0;
        end else begin
            x_valid_r      <= live & ~conflict;
            x_pc_r         <= xif.d_pc;
            x_wbr_r        <= (live & legal & ~conflict) ? xif.d_wbr : 6'd0;
            x_res_r        <= alu_res;
            x_opcode_r     <= xif.d_opcode;
            x_address_r    <= op1 + simm;
            x_store_data_r <= rtv;
            x_restart_r    <= conflict | br_restart;
            x_restart_pc_r <= conflict ? xif.d_pc : br_target;
            x_flush_d_r    <= conflict;
            kill_next      <= conflict;
        end
    end

    // One iteration of the multiply (shift-add) or divide (restoring) datapath
    logic [32:0] md_sum, md_trial, md_diff;
    logic        md_ge;
    always_comb begin
        md_sum   = {1'b0, md_p[63:32]} + (md_p[0] ? {1'b0, md_a} : 33'd0);
        md_trial = md_p[63:31];
        md_ge    = (md_trial >= {1'b0, md_a});
        md_diff  = md_trial - {1'b0, md_a};
        if (md_is_div) begin
            md_step = {(md_ge ? md_diff[31:0] : md_trial[31:0]), md_p[30:0], md_ge};
        end else begin
            md_step = {md_sum, md_p[31:1]};
        end
    end

    // Sign fix-up applied to the final iteration before HI/LO are written
    logic [63:0] md_prod;
    logic [31:0] md_fin_hi, md_fin_lo;
    always_comb begin
        md_prod   = md_neg_lo ? (64'd0 - md_step) : md_step;
        md_fin_hi = md_prod[63:32];
        md_fin_lo = md_prod[31:0];
        if (md_is_div) begin
            md_fin_lo = md_neg_lo ? (32'd0 - md_step[31:0]) : md_step[31:0];
            md_fin_hi = md_neg_hi ? (32'd0 - md_step[63:32]) : md_step[63:32];
            if (md_div_zero) begin
                md_fin_lo = 32'hFFFF_FFFF;
            end
        end
    end

    // HI/LO unit: start on an idle MULT/DIV, iterate, write HI/LO on the last count; MTxx when idle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            md_a        <= '0;
            md_p        <= '0;
            md_cnt      <= '0;
            md_is_div   <= 1'b0;
            md_neg_lo   <= 1'b0;
            md_neg_hi   <= 1'b0;
            md_div_zero <= 1'b0;
        end else if (md_busy) begin
            md_p   <= md_step;
            md_cnt <= md_cnt - CW'(1);
            if (md_cnt == CW'(1)) begin
                hi <= md_fin_hi;
                lo <= md_fin_lo;
            end
        end else if (do_start) begin
            // Iterate on magnitudes; md_a is the multiplicand or the divisor
            md_a        <= (md_signed & (md_div ? op2[31] : op1[31])) ?
                           (32'd0 - (md_div ? op2 : op1)) : (md_div ? op2 : op1);
            md_p        <= {32'd0, ((md_signed & (md_div ? op1[31] : op2[31])) ?
                           (32'd0 - (md_div ? op1 : op2)) : (md_div ? op1 : op2))};
            md_cnt      <= CW'(MD_CYCLES);
            md_is_div   <= md_div;
            md_neg_lo   <= md_signed & (op1[31] ^ op2[31]);
            md_neg_hi   <= md_signed & op1[31];
            md_div_zero <= md_div & (op2 == 32'd0);
        end else if (do_mthi) begin
            hi <= op1;
        end else if (do_mtlo) begin
            lo <= op1;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, xif.d_rt[5], xif.d_rt[3:1], md_diff[32], debug};

    assign xif.x_valid      = x_valid_r;
    assign xif.x_pc         = x_pc_r;
    assign xif.x_wbr        = x_wbr_r;
    assign xif.x_res        = x_res_r;
    assign xif.x_opcode     = x_opcode_r;
    assign xif.x_address    = x_address_r;
    assign xif.x_store_data = x_store_data_r;
    assign xif.x_restart    = x_restart_r;
    assign xif.x_restart_pc = x_restart_pc_r;
    assign xif.x_flush_D    = x_flush_d_r;
    assign xif.x_md_busy    = md_busy;
endmodule

// File: tb/tb_stage_x.sv
// tb/tb_stage_x.sv - scoreboard bench for stage_x
module tb_stage_x;
    typedef struct {
        string       tag;
        bit          valid;
        logic [5:0]  wbr;
        bit          chk_res;
        logic [31:0] res;
        bit          restart;
        logic [31:0] rpc;
        bit          flush;
        bit          chk_busy;
        bit          busy;
        bit          chk_addr;
        logic [31:0] addr;
    } exp_t;

    localparam logic [5:0] SPC = 6'h00;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    stage_x_if xif();
    stage_x #(.MD_CYCLES(32), .debug(1'b0)) dut (.clock(clock), .rst_n(rst_n), .xif(xif));

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] pc;
    logic        g_ill;
    logic        g_flx;
    logic [5:0]  g_rt;
    logic [4:0]  g_sa;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input bit v, input logic [5:0] w, input bit cr,
                                input logic [31:0] r, input bit rs, input logic [31:0] rp, input bit fl);
        exp_t e;
        e.tag = tag; e.valid = v; e.wbr = w; e.chk_res = cr; e.res = r;
        e.restart = rs; e.rpc = rp; e.flush = fl;
        e.chk_busy = 1'b0; e.busy = 1'b0; e.chk_addr = 1'b0; e.addr = '0;
        return e;
    endfunction

    function automatic exp_t alu(input string tag, input logic [5:0] w, input logic [31:0] r);
        return mk(tag, 1'b1, w, 1'b1, r, 1'b0, 32'd0, 1'b0);
    endfunction

    function automatic exp_t nop(input string tag);
        return mk(tag, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endfunction

    function automatic exp_t busy_e(input exp_t e, input bit b);
        exp_t r;
        r = e; r.chk_busy = 1'b1; r.busy = b;
        return r;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [31:0] rtv, input logic [31:0] simm,
                         input logic [5:0] wbr, input logic [31:0] tgt, input exp_t e);
        @(negedge clock);
        xif.d_valid = 1'b1; xif.d_illegal_instr = g_ill; xif.d_flush_X = g_flx;
        xif.d_pc = pc; xif.d_npc = pc + 32'd4; xif.d_opcode = op; xif.d_fn = fn;
        xif.d_rt = g_rt; xif.d_sa = g_sa; xif.d_target = tgt; xif.d_wbr = wbr;
        xif.d_op1_val = op1; xif.d_op2_val = op2; xif.d_rt_val = rtv; xif.d_simm = simm;
        q.push_back(e);
        pc = pc + 32'd4;
        g_ill = 1'b0; g_flx = 1'b0; g_rt = 6'd0; g_sa = 5'd0;
    endtask

    // c is the expected unit counter after the first idle cycle
    task automatic idle(input int n, input bit chk_b, input int c);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            xif.d_valid = 1'b0;
            q.push_back(chk_b ? busy_e(nop("idle"), (c - i) > 0) : nop("idle"));
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clock); #2;
            k++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: compare each DUT result against the record pushed when its input was driven
    initial begin
        forever begin
            @(posedge clock); #1;
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check({mon_e.tag, ".valid"}, 32'(xif.x_valid), 32'(mon_e.valid));
                check({mon_e.tag, ".wbr"}, 32'(xif.x_wbr), 32'(mon_e.wbr));
                check({mon_e.tag, ".restart"}, 32'(xif.x_restart), 32'(mon_e.restart));
                check({mon_e.tag, ".flush_d"}, 32'(xif.x_flush_D), 32'(mon_e.flush));
                if (mon_e.chk_res) check({mon_e.tag, ".res"}, xif.x_res, mon_e.res);
                if (mon_e.restart) check({mon_e.tag, ".restart_pc"}, xif.x_restart_pc, mon_e.rpc);
                if (mon_e.chk_busy) check({mon_e.tag, ".md_busy"}, 32'(xif.x_md_busy), 32'(mon_e.busy));
                if (mon_e.chk_addr) check({mon_e.tag, ".address"}, xif.x_address, mon_e.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        xif.d_valid = 0; xif.d_illegal_instr = 0; xif.d_pc = 0; xif.d_npc = 0; xif.d_opcode = 0;
        xif.d_fn = 0; xif.d_rt = 0; xif.d_sa = 0; xif.d_target = 0; xif.d_wbr = 0;
        xif.d_op1_val = 0; xif.d_op2_val = 0; xif.d_rt_val = 0; xif.d_simm = 0; xif.d_flush_X = 0;
        g_ill = 0; g_flx = 0; g_rt = 0; g_sa = 0;
        pc = 32'h1000;

        repeat (3) @(posedge clock); #1;
        check("rst.valid", 32'(xif.x_valid), 32'd0);
        check("rst.res", xif.x_res, 32'd0);
        check("rst.restart", 32'(xif.x_restart), 32'd0);
        check("rst.md_busy", 32'(xif.x_md_busy), 32'd0);
        @(negedge clock) rst_n = 1'b1;

        // ALU
        issue(6'h09, 6'h00, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd1, 6'h22, 32'd0, alu("addiu", 6'h22, 32'h8000_0000));
        issue(SPC, 6'h23, 32'd5, 32'd7, 32'd7, 32'd0, 6'h23, 32'd0, alu("subu", 6'h23, 32'hFFFF_FFFE));
        issue(SPC, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 6'h24, 32'd0, alu("slt", 6'h24, 32'd1));
        issue(SPC, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 6'h24, 32'd0, alu("sltu", 6'h24, 32'd0));
        g_sa = 5'd4;
        issue(SPC, 6'h03, 32'd0, 32'd0, 32'h8000_0000, 32'd0, 6'h25, 32'd0, alu("sra", 6'h25, 32'hF800_0000));
        issue(SPC, 6'h04, 32'h24, 32'd1, 32'd1, 32'd0, 6'h25, 32'd0, alu("sllv", 6'h25, 32'h10));
        issue(6'h0D, 6'h00, 32'h10, 32'hFFFF_8001, 32'd0, 32'hFFFF_8001, 6'h26, 32'd0, alu("ori", 6'h26, 32'h8011));
        issue(6'h0F, 6'h00, 32'd0, 32'h1234, 32'd0, 32'h1234, 6'h26, 32'd0, alu("lui", 6'h26, 32'h1234_0000));
        issue(SPC, 6'h27, 32'h0F0F_0000, 32'h00FF_00FF, 32'd0, 32'd0, 6'h27, 32'd0, alu("nor", 6'h27, 32'hF000_FF00));
        e = alu("lw", 6'h28, 32'h0FFC); e.chk_addr = 1'b1; e.addr = 32'h0FFC;
        issue(6'h23, 6'h00, 32'h1000, 32'hFFFF_FFFC, 32'd0, 32'hFFFF_FFFC, 6'h28, 32'd0, e);
        g_ill = 1'b1;
        issue(SPC, 6'h21, 32'd1, 32'd2, 32'd0, 32'd0, 6'h29, 32'd0, mk("illegal", 1, 0, 0, 0, 0, 0, 0));
        g_flx = 1'b1;
        issue(SPC, 6'h21, 32'd1, 32'd2, 32'd0, 32'd0, 6'h29, 32'd0, nop("flush_x"));

        // Branches and jumps
        issue(6'h04, 6'h00, 32'd5, 32'd0, 32'd5, 32'd0, 6'h00, 32'h100, mk("beq_t", 1, 0, 0, 0, 1, 32'h100, 0));
        idle(1, 0, 0);
        issue(6'h04, 6'h00, 32'd5, 32'd0, 32'd6, 32'd0, 6'h00, 32'h100, mk("beq_nt", 1, 0, 0, 0, 0, 0, 0));
        issue(SPC, 6'h08, 32'h2000, 32'd0, 32'd0, 32'd0, 6'h00, 32'h0, mk("jr", 1, 0, 0, 0, 1, 32'h2000, 0));
        issue(6'h03, 6'h00, 32'd0, 32'd0, 32'd0, 32'd0, 6'h3F, 32'h400, mk("jal", 1, 6'h3F, 1, pc + 32'd8, 1, 32'h400, 0));
        g_rt = 6'h30;
        issue(6'h01, 6'h00, 32'd5, 32'd0, 32'd0, 32'd0, 6'h3F, 32'h500, mk("bltzal_nt", 1, 6'h3F, 1, pc + 32'd8, 0, 0, 0));
        g_rt = 6'h21;
        issue(6'h01, 6'h00, 32'd0, 32'd0, 32'd0, 32'd0, 6'h00, 32'h800, mk("bgez_t", 1, 0, 0, 0, 1, 32'h800, 0));
        issue(6'h07, 6'h00, 32'd0, 32'd0, 32'd0, 32'd0, 6'h00, 32'h900, mk("bgtz_nt", 1, 0, 0, 0, 0, 0, 0));

        // MULT -3 * 7, read after the unit finishes
        issue(SPC, 6'h18, 32'hFFFF_FFFD, 32'd7, 32'd7, 32'd0, 6'h00, 32'd0, busy_e(mk("mult", 1, 0, 0, 0, 0, 0, 0), 1));
        idle(40, 1, 31);
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mflo_mult", 6'h22, 32'hFFFF_FFEB));
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h23, 32'd0, alu("mfhi_mult", 6'h23, 32'hFFFF_FFFF));

        // DIVU 100/7 with an immediate MFLO conflict
        issue(SPC, 6'h1B, 32'd100, 32'd7, 32'd7, 32'd0, 6'h00, 32'd0, mk("divu", 1, 0, 0, 0, 0, 0, 0));
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, busy_e(mk("mflo_conf", 0, 0, 0, 0, 1, pc, 1), 1));
        issue(SPC, 6'h21, 32'd1, 32'd1, 32'd0, 32'd0, 6'h24, 32'd0, nop("killed"));
        idle(30, 1, 29);
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mflo_divu", 6'h22, 32'd14));
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h23, 32'd0, alu("mfhi_divu", 6'h23, 32'd2));

        // DIV 9/0, MFHI lands in the completion cycle
        issue(SPC, 6'h1A, 32'd9, 32'd0, 32'd0, 32'd0, 6'h00, 32'd0, busy_e(mk("div0", 1, 0, 0, 0, 0, 0, 0), 1));
        idle(31, 1, 31);
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, busy_e(mk("mfhi_last", 0, 0, 0, 0, 1, pc, 1), 0));
        issue(SPC, 6'h21, 32'd1, 32'd1, 32'd0, 32'd0, 6'h24, 32'd0, nop("killed2"));
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mfhi_div0", 6'h22, 32'd9));
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h23, 32'd0, alu("mflo_div0", 6'h23, 32'hFFFF_FFFF));

        // Signed DIV -7/2, then MTLO
        issue(SPC, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'd0, 6'h00, 32'd0, mk("div_s", 1, 0, 0, 0, 0, 0, 0));
        idle(34, 0, 0);
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mflo_divs", 6'h22, 32'hFFFF_FFFD));
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h23, 32'd0, alu("mfhi_divs", 6'h23, 32'hFFFF_FFFF));
        issue(SPC, 6'h13, 32'h55, 32'd0, 32'd0, 32'd0, 6'h00, 32'd0, mk("mtlo", 1, 0, 0, 0, 0, 0, 0));
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mflo_mt", 6'h22, 32'h55));

        // Reset in the middle of a divide (counter at 10)
        issue(SPC, 6'h1B, 32'd100, 32'd7, 32'd7, 32'd0, 6'h00, 32'd0, mk("divu2", 1, 0, 0, 0, 0, 0, 0));
        idle(22, 1, 31);
        drain();
        rst_n = 1'b0;
        #1;
        check("rst2.valid", 32'(xif.x_valid), 32'd0);
        check("rst2.res", xif.x_res, 32'd0);
        check("rst2.pc", xif.x_pc, 32'd0);
        check("rst2.md_busy", 32'(xif.x_md_busy), 32'd0);
        @(negedge clock) rst_n = 1'b1;
        issue(SPC, 6'h10, 32'd0, 32'd0, 32'd0, 32'd0, 6'h22, 32'd0, alu("mfhi_rst", 6'h22, 32'd0));
        issue(SPC, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 6'h23, 32'd0, alu("mflo_rst", 6'h23, 32'd0));
        g_flx = 1'b1;
        issue(SPC, 6'h21, 32'd3, 32'd4, 32'd0, 32'd0, 6'h25, 32'd0, nop("flush_x2"));
        idle(1, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_x.md
Name: stage_X

Overview:
- Execute stage of the yari-core pipeline, directly downstream of the decode stage. Consumes the registered decode outputs and produces the registered X-stage result (x_valid/x_wbr/x_res) that feeds decode's bypass network and the memory stage.
- Resolves branches and jumps by issuing restarts.
- Adds an iterative HI/LO multiply/divide unit; an access that conflicts with a busy unit restarts that instruction.

Parameters:
- MD_CYCLES, 32, iterations per MULT/MULTU/DIV/DIVU (one result bit per cycle).
- debug, 0, enables $display tracing; no functional effect.

Ports:
- clock  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- d_valid  in  1  decode slot holds a live instruction
- d_illegal_instr  in  1  unsupported instruction; treated as NOP
- d_pc, d_npc  in  32  instruction address / address+4
- d_opcode, d_fn  in  6  primary opcode / function field
- d_rt  in  6  {valid, rt} (REGIMM condition select)
- d_sa  in  5  shift amount
- d_target  in  32  precomputed branch/jump target
- d_wbr  in  6  writeback register; bit 5 = valid
- d_op1_val, d_op2_val, d_rt_val  in  32  forwarded rs, op2 (imm or rt), rt
- d_simm  in  32  sign-extended immediate
- d_flush_X  in  1  kill the instruction arriving this cycle
- x_valid  out  1  X result live
- x_pc  out  32  PC of X instruction
- x_wbr  out  6  writeback register (0 = none)
- x_res  out  32  ALU/link/HI/LO result
- x_opcode  out  6  opcode for memory stage
- x_address  out  32  op1+simm, load/store effective address
- x_store_data  out  32  d_rt_val
- x_restart  out  1  one-cycle restart pulse to fetch
- x_restart_pc  out  32  restart address
- x_flush_D  out  1  squash the instruction currently in D
- x_md_busy  out  1  multiply/divide unit iterating

Behaviour:
- Reset (async, rst_n=0): all outputs 0; HI, LO, md counter, kill_next = 0. On release, first edge behaves as idle.
- Latency: one cycle. Every output is registered from the D-stage inputs of the previous edge.
- Live = d_valid & ~d_flush_X & ~kill_next. Non-live: x_valid=0, x_wbr=0, x_restart=0, and no HI/LO or md state change.
- d_illegal_instr live: x_valid=1, x_wbr=0, no other side effect.
- ALU results (32-bit, wrap, no overflow trap):
  - ADDU/ADDIU/loads/stores: op1+op2.
  - SUBU: op1-op2.
  - AND/OR/XOR/NOR: on op2.
  - ANDI/ORI/XORI: zero-extended simm[15:0].
  - LUI: {simm[15:0],16'h0}.
  - SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare; result 0/1.
  - SLL/SRL/SRA: rt_val by d_sa. SLLV/SRLV/SRAV: rt_val by op1[4:0].
  - JAL/JALR/BLTZAL/BGEZAL: d_npc+4.
- Branches:
  - BEQ/BNE compare op1 with rt_val.
  - BLEZ/BGTZ and REGIMM BLTZ/BGEZ(AL) test op1 sign/zero; REGIMM selected by d_rt[0].
  - Taken branch, J, JAL: x_restart=1, x_restart_pc=d_target, x_flush_D=0 (delay slot in D proceeds).
  - JR/JALR: same, with x_restart_pc = op1.
  - Not-taken branches: no restart. Link regs write d_npc+4 whether taken or not.
- HI/LO unit:
  - MULT/MULTU/DIV/DIVU live and idle: latch operands (signed ops on magnitudes with sign fix-up at completion), counter=MD_CYCLES, x_md_busy=1 from the next cycle.
  - Counter decrements each cycle. At 1, HI/LO are written and busy drops on the following edge.
  - MULT: {HI,LO}=64-bit product. DIV: LO=quotient, HI=remainder (remainder takes sign of dividend).
  - Divisor 0: LO=32'hFFFFFFFF, HI=dividend; same cycle count.
  - MFHI/MFLO idle: x_res=HI/LO, x_wbr=d_wbr.
  - MTHI/MTLO idle: HI/LO=op1 at that edge.
- Busy conflict (any MULT/DIV/MFxx/MTxx live while busy, including completion cycle):
  - x_valid=0, x_wbr=0, x_restart=1, x_restart_pc=d_pc, x_flush_D=1, kill_next=1.
  - kill_next clears after one cycle. Unit continues undisturbed.
- Priority when simultaneous: reset > d_flush_X/kill_next > busy conflict > branch restart.
- A branch in X never co-occurs with a busy conflict (same instruction slot).

Test Plan:
- ADDIU op1=32'h7FFFFFFF, simm=1, d_wbr=6'h22 -> next cycle x_res=32'h80000000, x_wbr=6'h22, x_valid=1, no restart.
- BEQ op1=rt_val=5, d_target=32'h100 -> x_restart=1 for exactly one cycle, x_restart_pc=32'h100, x_flush_D=0. Same with rt_val=6 -> no restart.
- MULT op1=-3, op2=7, then MFLO 40 cycles later -> x_res=32'hFFFFFFEB; MFHI -> 32'hFFFFFFFF.
- DIVU 100/7 followed immediately by MFLO -> restart to MFLO pc, x_flush_D=1, next input killed; MFLO reissued after busy drops -> 14; MFHI -> 2.
- DIV by 0 with dividend 9 -> LO=32'hFFFFFFFF, HI=9 after MD_CYCLES+1 cycles.
- rst_n pulsed low mid-divide (counter=10) -> all outputs 0 immediately, x_md_busy=0, HI=LO=0. Assert d_flush_X with valid ADDU -> x_valid=0.
